// File: rtl/decode_addr_mode_seq.sv
// Sequential x86 address-mode decoder.
// Consumes a ModR/M byte, an optional SIB byte and an optional displacement from the
// prefetch stream, one byte per handshake. It emits one registered effective-address
// record per operand.
//
// Optional feature macro: DECODE_ADDR16_EN
//   Defined   : 16-bit addressing is decoded and addr_size_32 is honoured.
//   Undefined : addr_size_32 is ignored (treated as 1) and the 16-bit decode is not built.
//
// Ports
//   clock, reset_n      core clock, asynchronous active-low reset
//   flush               synchronous abort of the partial operand and of any held record
//   in_valid/in_ready   byte-stream handshake; in_byte is the data
//   in_start            in_byte is the ModR/M byte of a new operand
//   addr_size_32        address-size attribute, sampled with the ModR/M byte
//   out_valid/out_ready record handshake; the out_* fields form the record
//   proto_err           one-cycle pulse when in_start arrives mid-operand
module decode_addr_mode_seq #(
   parameter int unsigned DISP_W    = 32,
   parameter int unsigned UNDEF_CHK = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_byte,
   input  logic              in_start,
   input  logic              addr_size_32,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_mod,
   output logic [2:0]        out_reg,
   output logic              out_is_reg,
   output logic              out_base_used,
   output logic [2:0]        out_base_idx,
   output logic              out_index_used,
   output logic [2:0]        out_index_idx,
   output logic [1:0]        out_scale,
   output logic [DISP_W-1:0] out_disp,
   output logic              out_seg_ss,
   output logic              out_ea_undefined,
   output logic [2:0]        out_byte_count,
   output logic              proto_err
);

   typedef enum logic [1:0] {StIdle, StSib, StDisp} state_e;

   typedef struct packed {
      logic [1:0]        mod;
      logic [2:0]        rg;
      logic              is_reg;
      logic              base_used;
      logic [2:0]        base_idx;
      logic              index_used;
      logic [2:0]        index_idx;
      logic [1:0]        scale;
      logic [DISP_W-1:0] disp;
      logic              seg_ss;
      logic              undef;
      logic [2:0]        bcnt;
   } rec_t;

   state_e      state_q, state_d;
   logic [1:0]  mod_q, mod_d;
   logic [2:0]  reg_q, reg_d;
   logic [2:0]  rm_q, rm_d;
   logic        a32_q, a32_d;
   logic [7:0]  sib_q, sib_d;
   logic [2:0]  dlen_q, dlen_d;
   logic [2:0]  didx_q, didx_d;
   logic [31:0] disp_q, disp_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic        valid_q, valid_d;
   logic        perr_q, perr_d;
   rec_t        rec_q, rec_d, rec_c;
   logic        done;
   logic        hs;
   logic        a32_in;
   logic [31:0] dext;

`ifdef DECODE_ADDR16_EN
   assign a32_in = addr_size_32;
`else
   // Input kept referenced; 32-bit addressing is forced.
   assign a32_in = addr_size_32 | 1'b1;
`endif

   assign in_ready = ~valid_q | out_ready;
   assign hs       = in_valid & in_ready & ~flush;

   // Displacement length in bytes for a decoded ModR/M (and SIB base when present).
   function automatic logic [2:0] disp_len(input logic [1:0] m, input logic [2:0] r,
                                           input logic a32, input logic sibp,
                                           input logic [2:0] sbase);
      logic [2:0] len;
      len = 3'd0;
      if (a32) begin
         case (m)
            2'b01:   len = 3'd1;
            2'b10:   len = 3'd4;
            2'b00:   if ((sibp ? sbase : r) == 3'd5) len = 3'd4;
            default: len = 3'd0;
         endcase
      end
`ifdef DECODE_ADDR16_EN
      else begin
         case (m)
            2'b01:   len = 3'd1;
            2'b10:   len = 3'd2;
            2'b00:   if (r == 3'd6) len = 3'd2;
            default: len = 3'd0;
         endcase
      end
`endif
      return len;
   endfunction

   always_comb begin
      state_d = state_q;
      mod_d   = mod_q;
      reg_d   = reg_q;
      rm_d    = rm_q;
      a32_d   = a32_q;
      sib_d   = sib_q;
      dlen_d  = dlen_q;
      didx_d  = didx_q;
      disp_d  = disp_q;
      bcnt_d  = bcnt_q;
      done    = 1'b0;
      perr_d  = 1'b0;
      if (hs) begin
         if (in_start) begin
            // A start byte always opens a new operand, abandoning any partial one.
            perr_d = (state_q != StIdle);
            mod_d  = in_byte[7:6];
            reg_d  = in_byte[5:3];
            rm_d   = in_byte[2:0];
            a32_d  = a32_in;
            sib_d  = 8'h00;
            disp_d = 32'h0;
            didx_d = 3'd0;
            bcnt_d = 3'd1;
            dlen_d = disp_len(in_byte[7:6], in_byte[2:0], a32_in, 1'b0, 3'd0);
            if (a32_in && (in_byte[7:6] != 2'b11) && (in_byte[2:0] == 3'd4)) begin
               state_d = StSib;
            end else if (dlen_d != 3'd0) begin
               state_d = StDisp;
            end else begin
               state_d = StIdle;
               done    = 1'b1;
            end
         end else begin
            case (state_q)
               StSib: begin
                  sib_d  = in_byte;
                  bcnt_d = bcnt_q + 3'd1;
                  dlen_d = disp_len(mod_q, rm_q, a32_q, 1'b1, in_byte[2:0]);
                  if (dlen_d != 3'd0) begin
                     state_d = StDisp;
                  end else begin
                     state_d = StIdle;
                     done    = 1'b1;
                  end
               end
               StDisp: begin
                  case (didx_q[1:0])
                     2'd0:    disp_d[7:0]   = in_byte;
                     2'd1:    disp_d[15:8]  = in_byte;
                     2'd2:    disp_d[23:16] = in_byte;
                     default: disp_d[31:24] = in_byte;
                  endcase
                  didx_d = didx_q + 3'd1;
                  bcnt_d = bcnt_q + 3'd1;
                  if (didx_d == dlen_q) begin
                     state_d = StIdle;
                     done    = 1'b1;
                  end
               end
               default: ; // stray byte outside an operand is dropped
            endcase
         end
      end
      if (flush) begin
         state_d = StIdle;
      end
   end

   // Record decode from the post-update operand state, so it is valid in the final cycle.
   always_comb begin
      rec_c        = '0;
      rec_c.mod    = mod_d;
      rec_c.rg     = reg_d;
      rec_c.is_reg = (mod_d == 2'b11);
      rec_c.bcnt   = bcnt_d;
      if (mod_d != 2'b11) begin
         if (a32_d) begin
            if (rm_d == 3'd4) begin
               rec_c.base_used  = ~((mod_d == 2'b00) && (sib_d[2:0] == 3'd5));
               rec_c.base_idx   = rec_c.base_used ? sib_d[2:0] : 3'd0;
               rec_c.index_used = (sib_d[5:3] != 3'd4);
               rec_c.index_idx  = rec_c.index_used ? sib_d[5:3] : 3'd0;
               rec_c.scale      = sib_d[7:6];
               rec_c.undef      = (UNDEF_CHK != 0) && (sib_d[5:3] == 3'd4) &&
                                  (sib_d[7:6] != 2'b00);
            end else begin
               rec_c.base_used = ~((mod_d == 2'b00) && (rm_d == 3'd5));
               rec_c.base_idx  = rec_c.base_used ? rm_d : 3'd0;
            end
            // ESP/EBP based addressing defaults to the stack segment.
            rec_c.seg_ss = rec_c.base_used && (rec_c.base_idx[2:1] == 2'b10);
         end
`ifdef DECODE_ADDR16_EN
         else begin
            case (rm_d)
               3'd0: begin rec_c.base_used = 1'b1; rec_c.base_idx = 3'd3;
                           rec_c.index_used = 1'b1; rec_c.index_idx = 3'd6; end
               3'd1: begin rec_c.base_used = 1'b1; rec_c.base_idx = 3'd3;
                           rec_c.index_used = 1'b1; rec_c.index_idx = 3'd7; end
               3'd2: begin rec_c.base_used = 1'b1; rec_c.base_idx = 3'd5;
                           rec_c.index_used = 1'b1; rec_c.index_idx = 3'd6; end
               3'd3: begin rec_c.base_used = 1'b1; rec_c.base_idx = 3'd5;
                           rec_c.index_used = 1'b1; rec_c.index_idx = 3'd7; end
               3'd4: begin rec_c.index_used = 1'b1; rec_c.index_idx = 3'd6; end
               3'd5: begin rec_c.index_used = 1'b1; rec_c.index_idx = 3'd7; end
               3'd6: begin
                  // mod 00 with rm 110 is a bare disp16.
                  if (mod_d != 2'b00) begin
                     rec_c.base_used = 1'b1;
                     rec_c.base_idx  = 3'd5;
                  end
               end
               default: begin rec_c.base_used = 1'b1; rec_c.base_idx = 3'd3; end
            endcase
            rec_c.seg_ss = rec_c.base_used && (rec_c.base_idx == 3'd5);
         end
`endif
      end
      case (dlen_d)
         3'd1:    dext = {{24{disp_d[7]}}, disp_d[7:0]};
         3'd2:    dext = {{16{disp_d[15]}}, disp_d[15:0]};
         3'd4:    dext = disp_d;
         default: dext = 32'h0;
      endcase
      rec_c.disp = dext[DISP_W-1:0];
   end

   always_comb begin
      rec_d   = done ? rec_c : rec_q;
      valid_d = (valid_q & ~out_ready) | done;
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         mod_q   <= 2'd0;
         reg_q   <= 3'd0;
         rm_q    <= 3'd0;
         a32_q   <= 1'b0;
         sib_q   <= 8'h00;
         dlen_q  <= 3'd0;
         didx_q  <= 3'd0;
         disp_q  <= 32'h0;
         bcnt_q  <= 3'd0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         rec_q   <= '0;
      end else begin
         state_q <= state_d;
         mod_q   <= mod_d;
         reg_q   <= reg_d;
         rm_q    <= rm_d;
         a32_q   <= a32_d;
         sib_q   <= sib_d;
         dlen_q  <= dlen_d;
         didx_q  <= didx_d;
         disp_q  <= disp_d;
         bcnt_q  <= bcnt_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         rec_q   <= rec_d;
      end
   end

   assign out_valid        = valid_q;
   assign proto_err        = perr_q;
   assign out_mod          = rec_q.mod;
   assign out_reg          = rec_q.rg;
   assign out_is_reg       = rec_q.is_reg;
   assign out_base_used    = rec_q.base_used;
   assign out_base_idx     = rec_q.base_idx;
   assign out_index_used   = rec_q.index_used;
   assign out_index_idx    = rec_q.index_idx;
   assign out_scale        = rec_q.scale;
   assign out_disp         = rec_q.disp;
   assign out_seg_ss       = rec_q.seg_ss;
   assign out_ea_undefined = rec_q.undef;
   assign out_byte_count   = rec_q.bcnt;

endmodule
